// File: rtl/branch_target_unit.sv
// Branch target unit: one-cycle branch destination computation with a
// valid/ready output register and a circular return-address stack.
module branch_target_unit #(
    parameter int XLEN        = 32,
    parameter int RAS_DEPTH   = 4,
    parameter int ALIGN_CHECK = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      branch_op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] reg_data,
    input  logic [XLEN-1:0] immediate,
    input  logic            link,
    input  logic            ret,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] branch_dest,
    output logic            misaligned,
    output logic            illegal_op,
    output logic [XLEN-1:0] ras_target,
    output logic            ras_valid,
    output logic            ras_overflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_PC_RELATIVE = 2'b01;
    localparam logic [1:0] OP_REG_OFFSET  = 2'b10;

    // Output register
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] dest_q, dest_d;
    logic            mis_q, mis_d;
    logic            ill_q, ill_d;

    // Return-address stack: ptr_q is the next push slot, top is ptr_q-1
    logic [XLEN-1:0] entries_q [RAS_DEPTH];
    logic [XLEN-1:0] entries_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             op_legal;
    logic [XLEN-1:0]  dest_calc;
    logic             mis_calc;
    logic [XLEN-1:0]  link_addr;
    logic [PTR_W-1:0] top_idx;
    logic             ras_full;
    logic             ras_empty;

    assign in_ready  = (!out_valid_q || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign op_legal  = (branch_op == OP_PC_RELATIVE) || (branch_op == OP_REG_OFFSET);
    assign link_addr = pc + XLEN'(4);
    assign top_idx   = ptr_q - PTR_W'(1);
    assign ras_full  = (count_q == CNT_W'(RAS_DEPTH));
    assign ras_empty = (count_q == '0);

    always_comb begin
        dest_calc = '0;
        case (branch_op)
            OP_PC_RELATIVE: dest_calc = pc + immediate;
            OP_REG_OFFSET:  dest_calc = (reg_data + immediate) & ~XLEN'(1);
            default:        dest_calc = '0;
        endcase
    end

    // Alignment is judged on the final target, after the bit-0 clear
    assign mis_calc = (ALIGN_CHECK != 0) && op_legal && (dest_calc[1:0] != 2'b00);

    always_comb begin
        out_valid_d = out_valid_q;
        dest_d      = dest_q;
        mis_d       = mis_q;
        ill_d       = ill_q;
        if (accept) begin
            out_valid_d = 1'b1;
            dest_d      = dest_calc;
            mis_d       = mis_calc;
            ill_d       = !op_legal;
        end else if (out_ready || flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        entries_d = entries_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (accept && op_legal) begin
            // A combined call/return on an empty stack degenerates to a push
            if (link && (!ret || ras_empty)) begin
                entries_d[ptr_q] = link_addr;
                ptr_d            = ptr_q + PTR_W'(1);
                if (ras_full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else if (link && ret) begin
                entries_d[top_idx] = link_addr;
            end else if (ret && !ras_empty) begin
                ptr_d   = top_idx;
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            dest_q      <= '0;
            mis_q       <= 1'b0;
            ill_q       <= 1'b0;
            ptr_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            dest_q      <= dest_d;
            mis_q       <= mis_d;
            ill_q       <= ill_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign branch_dest  = dest_q;
    assign misaligned   = mis_q;
    assign illegal_op   = ill_q;
    assign ras_valid    = !ras_empty;
    assign ras_target   = ras_empty ? '0 : entries_q[top_idx];
    assign ras_overflow = ovf_q;

endmodule

// File: tb/tb_branch_target_unit.sv
// Bench for branch_target_unit: directed scenarios plus a randomized run
// checked against a queue-based model of the return-address stack.
module tb_branch_target_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            in_valid = 1'b0;
    logic [1:0]      branch_op = 2'b00;
    logic [XLEN-1:0] pc = '0, reg_data = '0, immediate = '0;
    logic            link = 1'b0, ret = 1'b0, flush = 1'b0, out_ready = 1'b0;

    logic            in_ready, out_valid, misaligned, illegal_op, ras_valid, ras_overflow;
    logic [XLEN-1:0] branch_dest, ras_target;
    logic            na_in_ready, na_out_valid, na_misaligned, na_illegal_op, na_ras_valid, na_ras_overflow;
    logic [XLEN-1:0] na_branch_dest, na_ras_target;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit              m_valid;
    logic [XLEN-1:0] m_dest;
    bit              m_mis, m_ill, m_ovf;
    logic [XLEN-1:0] q[$];

    always #5 clk = ~clk;

    branch_target_unit #(.XLEN(XLEN), .RAS_DEPTH(DEPTH), .ALIGN_CHECK(1)) u_dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .branch_op(branch_op), .pc(pc), .reg_data(reg_data), .immediate(immediate),
        .link(link), .ret(ret), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .branch_dest(branch_dest), .misaligned(misaligned), .illegal_op(illegal_op),
        .ras_target(ras_target), .ras_valid(ras_valid), .ras_overflow(ras_overflow)
    );

    branch_target_unit #(.XLEN(XLEN), .RAS_DEPTH(DEPTH), .ALIGN_CHECK(0)) u_dut_na (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(na_in_ready),
        .branch_op(branch_op), .pc(pc), .reg_data(reg_data), .immediate(immediate),
        .link(link), .ret(ret), .flush(flush), .out_valid(na_out_valid), .out_ready(out_ready),
        .branch_dest(na_branch_dest), .misaligned(na_misaligned), .illegal_op(na_illegal_op),
        .ras_target(na_ras_target), .ras_valid(na_ras_valid), .ras_overflow(na_ras_overflow)
    );

    task automatic model_clear();
        m_valid = 0; m_dest = '0; m_mis = 0; m_ill = 0; m_ovf = 0;
        q.delete();
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [XLEN-1:0] pc_i,
                         input logic [XLEN-1:0] rd_i, input logic [XLEN-1:0] imm_i,
                         input logic lk, input logic rt, input logic fl, input logic ordy);
        in_valid = v; branch_op = op; pc = pc_i; reg_data = rd_i; immediate = imm_i;
        link = lk; ret = rt; flush = fl; out_ready = ordy;
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(0, 2'b00, '0, '0, '0, 0, 0, 0, ordy);
    endtask

    // Advance one clock; the model takes the same step from the pre-edge inputs
    task automatic tick();
        bit acc, legal;
        logic [XLEN-1:0] d, ra;
        acc   = resetn && in_valid && (!m_valid || out_ready) && !flush;
        legal = (branch_op == 2'b01) || (branch_op == 2'b10);
        case (branch_op)
            2'b01:   d = pc + immediate;
            2'b10:   d = (reg_data + immediate) & 32'hFFFF_FFFE;
            default: d = '0;
        endcase
        ra = pc + 32'd4;
        @(posedge clk);
        if (!resetn) begin
            model_clear();
        end else if (acc) begin
            m_valid = 1; m_dest = d; m_ill = !legal;
            m_mis = legal && (d[1:0] != 2'b00);
            if (legal) begin
                if (link && ret && q.size() != 0) begin
                    q[q.size()-1] = ra;
                end else if (link) begin
                    if (q.size() == DEPTH) begin
                        void'(q.pop_front());
                        m_ovf = 1;
                    end
                    q.push_back(ra);
                end else if (ret && q.size() != 0) begin
                    void'(q.pop_back());
                end
            end
        end else if (out_ready || flush) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 0;
        idle(1);
        @(posedge clk);
        @(negedge clk);
        resetn = 1;
        model_clear();
    endtask

    task automatic test_reset();
        idle(1);
        @(negedge clk);
        checks += 7;
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (branch_dest !== '0)    begin errors++; $display("FAIL reset_dest got %h want 0", branch_dest); end
        if (misaligned !== 1'b0)   begin errors++; $display("FAIL reset_mis got %b want 0", misaligned); end
        if (illegal_op !== 1'b0)   begin errors++; $display("FAIL reset_ill got %b want 0", illegal_op); end
        if (ras_valid !== 1'b0)    begin errors++; $display("FAIL reset_ras_valid got %b want 0", ras_valid); end
        if (ras_target !== '0)     begin errors++; $display("FAIL reset_ras_target got %h want 0", ras_target); end
        if (ras_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ras_overflow); end
        resetn = 1;
        model_clear();
        drive(1, 2'b01, 32'h0000_0200, '0, 32'h10, 0, 0, 0, 1);
        tick();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL first_accept_valid got %b want 1", out_valid); end
        if (branch_dest !== 32'h210) begin errors++; $display("FAIL first_accept_dest got %h want 00000210", branch_dest); end
        $display("reset: checks %0d errors %0d", checks, errors);
    endtask

    task automatic test_pc_relative();
        apply_reset();
        drive(1, 2'b01, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFF8, 0, 0, 0, 1);
        tick();
        checks += 4;
        if (out_valid !== 1'b1)          begin errors++; $display("FAIL pcrel_valid got %b want 1", out_valid); end
        if (branch_dest !== 32'h0000_00F8) begin errors++; $display("FAIL pcrel_dest got %h want 000000f8", branch_dest); end
        if (misaligned !== 1'b0)         begin errors++; $display("FAIL pcrel_mis got %b want 0", misaligned); end
        if (illegal_op !== 1'b0)         begin errors++; $display("FAIL pcrel_ill got %b want 0", illegal_op); end
        idle(1);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL pcrel_drain got %b want 0", out_valid); end
        $display("pc_relative: checks %0d errors %0d", checks, errors);
    endtask

    task automatic test_reg_offset();
        logic [XLEN-1:0] rd_t  [3] = '{32'h2001, 32'h1000, 32'h1001};
        logic [XLEN-1:0] imm_t [3] = '{32'h2,    32'h3,    32'h3};
        logic [XLEN-1:0] exp_t [3] = '{32'h2002, 32'h1002, 32'h1004};
        bit              mis_t [3] = '{1'b1,     1'b1,     1'b0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b10, 32'h5555_0000, rd_t[i], imm_t[i], 0, 0, 0, 1);
            tick();
            checks += 4;
            if (branch_dest !== exp_t[i]) begin errors++; $display("FAIL regoff_dest[%0d] got %h want %h", i, branch_dest, exp_t[i]); end
            if (misaligned !== mis_t[i])  begin errors++; $display("FAIL regoff_mis[%0d] got %b want %b", i, misaligned, mis_t[i]); end
            if (na_branch_dest !== exp_t[i]) begin errors++; $display("FAIL regoff_na_dest[%0d] got %h want %h", i, na_branch_dest, exp_t[i]); end
            if (na_misaligned !== 1'b0)   begin errors++; $display("FAIL regoff_na_mis[%0d] got %b want 0", i, na_misaligned); end
        end
        $display("reg_offset: checks %0d errors %0d", checks, errors);
    endtask

    task automatic test_ras();
        logic [XLEN-1:0] pop_t [3] = '{32'h44, 32'h34, 32'h24};
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 2'b01, XLEN'(i * 16), '0, 32'h8, 1, 0, 0, 1);
            tick();
        end
        checks += 3;
        if (ras_overflow !== 1'b1)  begin errors++; $display("FAIL ras_ovf got %b want 1", ras_overflow); end
        if (ras_target !== 32'h54)  begin errors++; $display("FAIL ras_top got %h want 00000054", ras_target); end
        if (ras_valid !== 1'b1)     begin errors++; $display("FAIL ras_valid_full got %b want 1", ras_valid); end
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'b01, 32'h900, '0, 32'h8, 0, 1, 0, 1);
            tick();
            checks++;
            if (i < 3) begin
                if (ras_target !== pop_t[i]) begin errors++; $display("FAIL ras_pop[%0d] got %h want %h", i, ras_target, pop_t[i]); end
            end else begin
                if (ras_valid !== 1'b0 || ras_target !== '0) begin
                    errors++; $display("FAIL ras_empty[%0d] got valid %b target %h want 0 0", i, ras_valid, ras_target);
                end
            end
        end
        drive(1, 2'b01, 32'h600, '0, 32'h8, 1, 1, 0, 1);
        tick();
        drive(1, 2'b01, 32'h700, '0, 32'h8, 1, 0, 0, 1);
        tick();
        drive(1, 2'b10, 32'h800, 32'h0, 32'h8, 1, 1, 0, 1);
        tick();
        checks++;
        if (ras_target !== 32'h804) begin errors++; $display("FAIL ras_swap got %h want 00000804", ras_target); end
        drive(1, 2'b01, 32'h0, '0, 32'h8, 0, 1, 0, 1);
        tick();
        checks += 2;
        if (ras_target !== 32'h604) begin errors++; $display("FAIL ras_after_swap got %h want 00000604", ras_target); end
        if (ras_overflow !== 1'b1)  begin errors++; $display("FAIL ras_ovf_sticky got %b want 1", ras_overflow); end
        $display("ras: checks %0d errors %0d", checks, errors);
    endtask

    task automatic test_stall();
        apply_reset();
        drive(1, 2'b01, 32'h1000, '0, 32'h4, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b01, 32'h2000, '0, 32'h4, 0, 0, 0, 0);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || branch_dest !== 32'h1004) begin
                errors++; $display("FAIL stall_hold[%0d] got valid %b dest %h want 1 00001004", i, out_valid, branch_dest);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b01, 32'h2000 + XLEN'(i * 32'h100), '0, 32'h4, 0, 0, 0, 1);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || branch_dest !== 32'h2004 + XLEN'(i * 32'h100)) begin
                errors++; $display("FAIL b2b_dest[%0d] got valid %b dest %h want 1 %h", i, out_valid, branch_dest, 32'h2004 + i * 32'h100);
            end
        end
        idle(1);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
        $display("stall_back_to_back: checks %0d errors %0d", checks, errors);
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1, 2'b01, 32'h300, '0, 32'h8, 1, 0, 0, 0);
        tick();
        drive(1, 2'b01, 32'h700, '0, 32'h8, 1, 0, 1, 0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
        tick();
        checks += 2;
        if (out_valid !== 1'b0)     begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
        if (ras_target !== 32'h304) begin errors++; $display("FAIL flush_ras got %h want 00000304", ras_target); end
        drive(1, 2'b01, 32'h0, '0, 32'h8, 0, 1, 0, 1);
        tick();
        checks++;
        if (ras_valid !== 1'b0) begin errors++; $display("FAIL flush_count got %b want 0", ras_valid); end
        $display("flush: checks %0d errors %0d", checks, errors);
    endtask

    task automatic test_illegal();
        logic [1:0] bad_t [2] = '{2'b11, 2'b00};
        apply_reset();
        drive(1, 2'b01, 32'h80, '0, 32'h8, 1, 0, 0, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, bad_t[i], 32'h91, 32'h33, 32'h5, 1, 0, 0, 1);
            tick();
            checks += 4;
            if (illegal_op !== 1'b1)   begin errors++; $display("FAIL ill_flag[%0d] got %b want 1", i, illegal_op); end
            if (branch_dest !== '0)    begin errors++; $display("FAIL ill_dest[%0d] got %h want 0", i, branch_dest); end
            if (misaligned !== 1'b0)   begin errors++; $display("FAIL ill_mis[%0d] got %b want 0", i, misaligned); end
            if (ras_target !== 32'h84) begin errors++; $display("FAIL ill_ras[%0d] got %h want 00000084", i, ras_target); end
        end
        drive(1, 2'b01, 32'h40, '0, 32'h8, 1, 0, 0, 1);
        tick();
        idle(0);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ill_stall_valid got %b want 1", out_valid); end
        #2;
        resetn = 0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL async_valid got %b want 0", out_valid); end
        if (branch_dest !== '0)    begin errors++; $display("FAIL async_dest got %h want 0", branch_dest); end
        if (ras_valid !== 1'b0)    begin errors++; $display("FAIL async_ras_valid got %b want 0", ras_valid); end
        if (ras_target !== '0)     begin errors++; $display("FAIL async_ras_target got %h want 0", ras_target); end
        if (illegal_op !== 1'b0 || misaligned !== 1'b0) begin
            errors++; $display("FAIL async_flags got ill %b mis %b want 0 0", illegal_op, misaligned);
        end
        drive(1, 2'b01, 32'h123, '0, 32'h1, 1, 0, 0, 1);
        tick();
        checks++;
        if (out_valid !== 1'b0 || ras_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_accept got valid %b ras %b want 0 0", out_valid, ras_valid);
        end
        resetn = 1;
        model_clear();
        $display("illegal: checks %0d errors %0d", checks, errors);
    endtask

    task automatic test_random();
        logic [XLEN-1:0] exp_top;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                  $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 64)) : $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
            checks++;
            if (in_ready !== ((!m_valid || out_ready) && !flush)) begin
                errors++; $display("FAIL rnd_ready[%0d] got %b want %b", n, in_ready, (!m_valid || out_ready) && !flush);
            end
            tick();
            exp_top = (q.size() != 0) ? q[q.size()-1] : '0;
            checks += 4;
            if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", n, out_valid, m_valid); end
            if (ras_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_ras_valid[%0d] got %b want %b", n, ras_valid, q.size() != 0); end
            if (ras_target !== exp_top) begin errors++; $display("FAIL rnd_ras_target[%0d] got %h want %h", n, ras_target, exp_top); end
            if (ras_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %b want %b", n, ras_overflow, m_ovf); end
            if (m_valid) begin
                checks += 4;
                if (branch_dest !== m_dest) begin errors++; $display("FAIL rnd_dest[%0d] got %h want %h", n, branch_dest, m_dest); end
                if (misaligned !== m_mis)   begin errors++; $display("FAIL rnd_mis[%0d] got %b want %b", n, misaligned, m_mis); end
                if (illegal_op !== m_ill)   begin errors++; $display("FAIL rnd_ill[%0d] got %b want %b", n, illegal_op, m_ill); end
                if (na_misaligned !== 1'b0) begin errors++; $display("FAIL rnd_na_mis[%0d] got %b want 0", n, na_misaligned); end
            end
        end
        $display("random: checks %0d errors %0d", checks, errors);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_pc_relative();
        test_reg_offset();
        test_ras();
        test_stall();
        test_flush();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
